scalar_add_ctrl: RTL and testbench

SCALAR_ADD_CTRL -- requirements
Module: scalar_add_ctrl

---
 rtl/cray_pkg.sv | 15 +
 rtl/scalar_pipe_track.sv | 35 +++
 rtl/scalar_add_ctrl.sv | 81 ++++++++
 tb/tb_scalar_add_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cray_pkg.sv
// Shared definitions for the Cray-style scalar functional unit controllers:
// S-register file geometry and scalar opcode constants.
package cray_pkg;

   localparam int NREG = 8;
   localparam int SAW  = 3;

   localparam logic [6:0] OP_SADD = 7'o060;
   localparam logic [6:0] OP_SSUB = 7'o061;

   function automatic logic is_sadd_op(input logic [6:0] op);
      return (op == OP_SADD) || (op == OP_SSUB);
   endfunction

endpackage

// File: rtl/scalar_pipe_track.sv
// LATENCY-deep {valid, dest} shift register that shadows a scalar unit's
// pipeline so the result write strobe lines up with the unit's output.
module scalar_pipe_track #(
   parameter int LATENCY = 3,
   parameter int AW      = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_valid,
   input  logic [AW-1:0] push_addr,
   output logic          out_valid,
   output logic [AW-1:0] out_addr
);

   logic [LATENCY-1:0] vld;
   logic [AW-1:0]      addr [LATENCY];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld <= '0;
         for (int s = 0; s < LATENCY; s++) addr[s] <= '0;
      end else begin
         vld[0]  <= push_valid;
         addr[0] <= push_addr;
         for (int s = 1; s < LATENCY; s++) begin
            vld[s]  <= vld[s-1];
            addr[s] <= addr[s-1];
         end
      end
   end

   assign out_valid = vld[LATENCY-1];
   assign out_addr  = addr[LATENCY-1];

endmodule

// File: rtl/scalar_add_ctrl.sv
// Issue/reservation controller for the scalar add unit: checks S-register
// hazards, issues to the unit and generates the delayed result write.
module scalar_add_ctrl
   import cray_pkg::*;
#(
   parameter int LATENCY = 3,
   parameter int NREG    = cray_pkg::NREG
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_issue_valid,
   input  logic [6:0]      i_instr,
   input  logic [2:0]      i_i,
   input  logic [2:0]      i_j,
   input  logic [2:0]      i_k,
   input  logic [NREG-1:0] i_ext_res,
   output logic            o_issue_ready,
   output logic            o_illegal,
   output logic [2:0]      o_rd_j,
   output logic [2:0]      o_rd_k,
   output logic            o_sj_zero,
   output logic [6:0]      o_fu_instr,
   output logic            o_wr_en,
   output logic [2:0]      o_wr_addr,
   output logic [NREG-1:0] o_res,
   output logic [15:0]     o_hold_cnt
);

   logic            legal;
   logic            conflict;
   logic            accept;
   logic [NREG-1:0] busy;
   logic [NREG-1:0] res_next;

   // Handshake: the instruction transfers in any cycle where i_issue_valid
   // and o_issue_ready are both high; ready is combinational and never
   // asserted for an illegal opcode, a register hazard, or during reset.
   assign busy     = o_res | i_ext_res;
   assign legal    = is_sadd_op(i_instr);
   assign conflict = busy[i_i] | busy[i_k] | ((i_j != 3'd0) & busy[i_j]);
   assign accept   = i_issue_valid & legal & ~conflict & ~rst;

   assign o_issue_ready = accept;
   assign o_rd_j        = i_j;
   assign o_rd_k        = i_k;
   assign o_sj_zero     = (i_j == 3'd0);
   assign o_fu_instr    = accept ? i_instr : 7'o000;

   scalar_pipe_track #(
      .LATENCY (LATENCY),
      .AW      (SAW)
   ) u_track (
      .clk        (clk),
      .rst        (rst),
      .push_valid (accept),
      .push_addr  (i_i),
      .out_valid  (o_wr_en),
      .out_addr   (o_wr_addr)
   );

   // Clear first, then set, so a same-edge set of the bit takes priority.
   always_comb begin
      res_next = o_res;
      if (o_wr_en) res_next[o_wr_addr] = 1'b0;
      if (accept)  res_next[i_i]       = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_res      <= '0;
         o_illegal  <= 1'b0;
         o_hold_cnt <= 16'd0;
      end else begin
         o_res     <= res_next;
         o_illegal <= i_issue_valid & ~legal;
         if (i_issue_valid && legal && conflict && (o_hold_cnt != 16'hFFFF))
            o_hold_cnt <= o_hold_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_scalar_add_ctrl.sv
// Bench for scalar_add_ctrl: hand-derived vector table, reset and saturation
// sequences, and random traffic against an in-flight-list reference model.
module tb_scalar_add_ctrl;

   localparam int L = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_issue_valid;
   logic [6:0]  i_instr;
   logic [2:0]  i_i, i_j, i_k;
   logic [7:0]  i_ext_res;
   logic        o_issue_ready, o_illegal, o_sj_zero, o_wr_en;
   logic [2:0]  o_rd_j, o_rd_k, o_wr_addr;
   logic [6:0]  o_fu_instr;
   logic [7:0]  o_res;
   logic [15:0] o_hold_cnt;

   int checks = 0;
   int errors = 0;

   // reference model: list of accepted instructions (cycle, destination)
   int          cyc = 0;
   int          acc_c[$];
   logic [2:0]  acc_d[$];
   logic [15:0] hold_m = 16'd0;
   logic        ill_m = 1'b0;

   typedef struct {
      logic       v;
      logic [6:0] op;
      logic [2:0] i, j, k;
      logic [7:0] ext;
      logic       rdy;
      logic       wen;
      logic [2:0] wa;
      logic [7:0] res;
      logic       ill;
      logic [15:0] hold;
   } vec_t;

   vec_t tbl[16];

   scalar_add_ctrl #(.LATENCY(L), .NREG(8)) dut (
      .clk           (clk),
      .rst           (rst),
      .i_issue_valid (i_issue_valid),
      .i_instr       (i_instr),
      .i_i           (i_i),
      .i_j           (i_j),
      .i_k           (i_k),
      .i_ext_res     (i_ext_res),
      .o_issue_ready (o_issue_ready),
      .o_illegal     (o_illegal),
      .o_rd_j        (o_rd_j),
      .o_rd_k        (o_rd_k),
      .o_sj_zero     (o_sj_zero),
      .o_fu_instr    (o_fu_instr),
      .o_wr_en       (o_wr_en),
      .o_wr_addr     (o_wr_addr),
      .o_res         (o_res),
      .o_hold_cnt    (o_hold_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic op_legal(input logic [6:0] op);
      return (op == 7'o060) || (op == 7'o061);
   endfunction

   function automatic logic [7:0] model_res();
      logic [7:0] r = 8'h00;
      foreach (acc_c[n])
         if (acc_c[n] < cyc && cyc <= acc_c[n] + L) r[acc_d[n]] = 1'b1;
      return r;
   endfunction

   function automatic logic model_conflict();
      logic [7:0] b = model_res() | i_ext_res;
      return b[i_i] || b[i_k] || (i_j != 3'd0 && b[i_j]);
   endfunction

   function automatic logic model_ready();
      return i_issue_valid && op_legal(i_instr) && !model_conflict() && !rst;
   endfunction

   task automatic drv(input logic v, input logic [6:0] op, input logic [2:0] i,
                      input logic [2:0] j, input logic [2:0] k, input logic [7:0] ext);
      i_issue_valid = v; i_instr = op; i_i = i; i_j = j; i_k = k; i_ext_res = ext;
   endtask

   task automatic model_check();
      logic       rdy = model_ready();
      logic       wf = 1'b0;
      logic [2:0] wa = 3'd0;
      foreach (acc_c[n])
         if (acc_c[n] + L == cyc) begin wf = 1'b1; wa = acc_d[n]; end
      chk("res", 32'(o_res), 32'(model_res()));
      chk("ready", 32'(o_issue_ready), 32'(rdy));
      chk("wr_en", 32'(o_wr_en), 32'(wf));
      if (wf) chk("wr_addr", 32'(o_wr_addr), 32'(wa));
      chk("illegal", 32'(o_illegal), 32'(ill_m));
      chk("hold", 32'(o_hold_cnt), 32'(hold_m));
      chk("rd_j", 32'(o_rd_j), 32'(i_j));
      chk("rd_k", 32'(o_rd_k), 32'(i_k));
      chk("sj_zero", 32'(o_sj_zero), 32'(i_j == 3'd0));
      chk("fu_instr", 32'(o_fu_instr), 32'(rdy ? i_instr : 7'o000));
   endtask

   task automatic advance();
      logic ill_next = i_issue_valid && !op_legal(i_instr);
      if (model_ready()) begin acc_c.push_back(cyc); acc_d.push_back(i_i); end
      if (i_issue_valid && op_legal(i_instr) && model_conflict() && hold_m != 16'hFFFF)
         hold_m = hold_m + 16'd1;
      @(posedge clk);
      cyc++;
      ill_m = ill_next;
      while (acc_c.size() > 0 && acc_c[0] + L < cyc) begin
         void'(acc_c.pop_front());
         void'(acc_d.pop_front());
      end
      @(negedge clk);
   endtask

   // asserted at a negedge: outputs must clear without waiting for an edge
   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_res", 32'(o_res), 32'h0);
      chk("rst_wr_en", 32'(o_wr_en), 32'h0);
      chk("rst_ready", 32'(o_issue_ready), 32'h0);
      chk("rst_hold", 32'(o_hold_cnt), 32'h0);
      chk("rst_illegal", 32'(o_illegal), 32'h0);
      acc_c.delete(); acc_d.delete();
      hold_m = 16'd0; ill_m = 1'b0;
      @(posedge clk);
      cyc++;
      #1;
      chk("rst_wr_en_edge", 32'(o_wr_en), 32'h0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      drv(1'b0, 7'o000, 3'd0, 3'd0, 3'd0, 8'h00);
      repeat (2) @(posedge clk);
      @(negedge clk);
      i_issue_valid = 1'b1; i_instr = 7'o060;
      #1;
      chk("reset_ready", 32'(o_issue_ready), 32'h0);
      chk("reset_res", 32'(o_res), 32'h0);
      chk("reset_hold", 32'(o_hold_cnt), 32'h0);
      chk("reset_wr_en", 32'(o_wr_en), 32'h0);
      rst = 1'b0;

      //               v     op      i     j     k     ext     rdy   wen   wa    res     ill   hold
      tbl[0]  = '{1'b1, 7'o060, 3'd3, 3'd1, 3'd2, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 16'd0};
      tbl[1]  = '{1'b1, 7'o060, 3'd5, 3'd3, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h08, 1'b0, 16'd0};
      tbl[2]  = '{1'b1, 7'o060, 3'd5, 3'd3, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h08, 1'b0, 16'd1};
      tbl[3]  = '{1'b1, 7'o060, 3'd5, 3'd3, 3'd0, 8'h00, 1'b0, 1'b1, 3'd3, 8'h08, 1'b0, 16'd2};
      tbl[4]  = '{1'b1, 7'o060, 3'd5, 3'd3, 3'd0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 16'd3};
      tbl[5]  = '{1'b1, 7'o062, 3'd1, 3'd2, 3'd3, 8'h00, 1'b0, 1'b0, 3'd0, 8'h20, 1'b0, 16'd3};
      tbl[6]  = '{1'b0, 7'o060, 3'd0, 3'd0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h20, 1'b1, 16'd3};
      tbl[7]  = '{1'b1, 7'o060, 3'd1, 3'd2, 3'd0, 8'h00, 1'b1, 1'b1, 3'd5, 8'h20, 1'b0, 16'd3};
      tbl[8]  = '{1'b1, 7'o061, 3'd2, 3'd0, 3'd4, 8'h00, 1'b1, 1'b0, 3'd0, 8'h02, 1'b0, 16'd3};
      tbl[9]  = '{1'b1, 7'o060, 3'd4, 3'd0, 3'd0, 8'h00, 1'b1, 1'b0, 3'd0, 8'h06, 1'b0, 16'd3};
      tbl[10] = '{1'b1, 7'o060, 3'd0, 3'd0, 3'd1, 8'h00, 1'b0, 1'b1, 3'd1, 8'h16, 1'b0, 16'd3};
      tbl[11] = '{1'b1, 7'o060, 3'd0, 3'd0, 3'd1, 8'h00, 1'b1, 1'b1, 3'd2, 8'h14, 1'b0, 16'd4};
      tbl[12] = '{1'b1, 7'o060, 3'd6, 3'd1, 3'd3, 8'h40, 1'b0, 1'b1, 3'd4, 8'h11, 1'b0, 16'd4};
      tbl[13] = '{1'b1, 7'o060, 3'd6, 3'd1, 3'd3, 8'h40, 1'b0, 1'b0, 3'd0, 8'h01, 1'b0, 16'd5};
      tbl[14] = '{1'b1, 7'o060, 3'd6, 3'd0, 3'd3, 8'h00, 1'b1, 1'b1, 3'd0, 8'h01, 1'b0, 16'd6};
      tbl[15] = '{1'b0, 7'o060, 3'd0, 3'd0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h40, 1'b0, 16'd6};

      for (int n = 0; n < 16; n++) begin
         drv(tbl[n].v, tbl[n].op, tbl[n].i, tbl[n].j, tbl[n].k, tbl[n].ext);
         #1;
         model_check();
         chk("tbl_ready", 32'(o_issue_ready), 32'(tbl[n].rdy));
         chk("tbl_res", 32'(o_res), 32'(tbl[n].res));
         chk("tbl_wr_en", 32'(o_wr_en), 32'(tbl[n].wen));
         if (tbl[n].wen) chk("tbl_wr_addr", 32'(o_wr_addr), 32'(tbl[n].wa));
         chk("tbl_illegal", 32'(o_illegal), 32'(tbl[n].ill));
         chk("tbl_hold", 32'(o_hold_cnt), 32'(tbl[n].hold));
         advance();
      end

      // reset two cycles after an accept cancels the pending write
      drv(1'b1, 7'o060, 3'd3, 3'd1, 3'd2, 8'h00);
      #1; model_check();
      chk("pre_rst_accept", 32'(o_issue_ready), 32'h1);
      advance();
      drv(1'b0, 7'o060, 3'd0, 3'd0, 3'd0, 8'h00);
      #1; model_check(); advance();
      drv(1'b1, 7'o060, 3'd7, 3'd1, 3'd2, 8'h00);
      do_reset();
      drv(1'b0, 7'o060, 3'd0, 3'd0, 3'd0, 8'h00);
      for (int n = 0; n < 4; n++) begin
         #1; model_check();
         chk("post_rst_no_wr", 32'(o_wr_en), 32'h0);
         advance();
      end

      for (int n = 0; n < 400; n++) begin
         logic [6:0] op;
         int         r = $urandom_range(0, 9);
         op = (r < 5) ? 7'o060 : (r < 9) ? 7'o061 : 7'($urandom_range(0, 127));
         drv(($urandom_range(0, 3) != 0), op, 3'($urandom_range(0, 7)),
             3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
             ($urandom_range(0, 3) == 0) ? 8'($urandom & $urandom) : 8'h00);
         if ($urandom_range(0, 99) == 0) begin
            do_reset();
         end else begin
            #1; model_check(); advance();
         end
      end

      // hold counter saturation under a permanent external reservation
      do_reset();
      drv(1'b1, 7'o060, 3'd0, 3'd0, 3'd0, 8'h01);
      repeat (65540) @(posedge clk);
      @(negedge clk);
      #1;
      chk("hold_saturate", 32'(o_hold_cnt), 32'hFFFF);
      chk("hold_sat_ready", 32'(o_issue_ready), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
